// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - SPI mode-0 frame transmitter, MSB first, active-low ss.
// Optional null-terminated frames: define SPI_NULL_TERM_EN.
module spi_frame_tx #(
  parameter int FRAME_BYTES    = 19,
  parameter int CLK_DIV        = 4,
  parameter int INTER_BYTE_GAP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     begin_transmission,
  input  logic [8*FRAME_BYTES-1:0] data_in,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     ss,
  output logic                     end_transmission,
  output logic                     busy,
  output logic [4:0]               byte_count
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int LW = $clog2(FRAME_BYTES + 1);
  localparam logic [15:0] DIV_TC = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_TC = 16'(INTER_BYTE_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t          state, state_next;
  logic [FW-1:0]   frame, frame_adv;
  logic [7:0]      shreg, next_byte;
  logic [LW-1:0]   bytes_left;
  logic [2:0]      bit_cnt;
  logic [15:0]     div_cnt, gap_cnt;
  logic            div_tc, gap_tc, byte_end, more, null_first, null_next;

  always_comb begin
    frame_adv  = frame << 8;
    next_byte  = frame_adv[FW-1 -: 8];
    div_tc     = (div_cnt == DIV_TC);
    gap_tc     = (gap_cnt == GAP_TC);
    byte_end   = div_tc && sclk && (bit_cnt == 3'd7);
    more       = (bytes_left != '0);
`ifdef SPI_NULL_TERM_EN
    // Byte 0 is only screened in its first SHIFT cycle; later bytes at GAP end.
    null_first = (byte_count == 5'd0) && (bit_cnt == 3'd0) && (div_cnt == 16'd0)
                 && !sclk && (shreg == 8'h00);
    null_next  = (next_byte == 8'h00);
`else
    null_first = 1'b0;
    null_next  = 1'b0;
`endif
    state_next = state;
    case (state)
      IDLE:  if (begin_transmission) state_next = SHIFT;
      SHIFT: begin
        if (null_first)    state_next = DONE;
        else if (byte_end) state_next = GAP;
      end
      GAP: begin
        if (gap_tc) state_next = (more && !null_next) ? SHIFT : DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk             <= 1'b0;
      mosi             <= 1'b0;
      ss               <= 1'b1;
      end_transmission <= 1'b0;
      busy             <= 1'b0;
      byte_count       <= 5'd0;
      frame            <= '0;
      shreg            <= 8'h00;
      bytes_left       <= '0;
      bit_cnt          <= 3'd0;
      div_cnt          <= 16'd0;
      gap_cnt          <= 16'd0;
    end else begin
      ss               <= !((state_next == SHIFT) || (state_next == GAP));
      end_transmission <= (state_next == DONE);
      busy             <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (begin_transmission) begin
            frame      <= data_in;
            shreg      <= data_in[FW-1 -: 8];
            mosi       <= data_in[FW-1];
            bytes_left <= LW'(FRAME_BYTES - 1);
            bit_cnt    <= 3'd0;
            div_cnt    <= 16'd0;
            sclk       <= 1'b0;
            byte_count <= 5'd0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= 16'd0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                byte_count <= byte_count + 5'd1;
                gap_cnt    <= 16'd0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], 1'b0};
                mosi    <= shreg[6];
              end
            end else begin
              sclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (state_next == SHIFT) begin
            frame      <= frame_adv;
            shreg      <= next_byte;
            mosi       <= next_byte[7];
            bytes_left <= bytes_left - LW'(1);
            bit_cnt    <= 3'd0;
            div_cnt    <= 16'd0;
          end
        end
        default: ;
      endcase
      // Closing the frame always parks the bus, whichever state it came from.
      if (state_next == DONE) begin
        mosi <= 1'b0;
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb/tb_spi_frame_tx.sv - directed bench for spi_frame_tx (default and small configurations).
module tb_spi_frame_tx;

`ifdef SPI_NULL_TERM_EN
  localparam int EXP_N = 18;
`else
  localparam int EXP_N = 19;
`endif
  localparam int EXP_END = 1 + EXP_N * 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, begin_tx, begin_s;
  logic [151:0] data_in;
  logic [7:0]   data_s;
  logic         sclk, mosi, ss, end_tx, busy;
  logic [4:0]   byte_count;
  logic         sclk_s, mosi_s, ss_s, end_s, busy_s;
  logic [4:0]   byte_count_s;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame_bytes [19] = '{8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33, 8'h34,
                                   8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
                                   8'h20, 8'h20, 8'h20, 8'h20, 8'h00};

  spi_frame_tx dut (
    .clk(clk), .rst(rst), .begin_transmission(begin_tx), .data_in(data_in),
    .sclk(sclk), .mosi(mosi), .ss(ss), .end_transmission(end_tx),
    .busy(busy), .byte_count(byte_count)
  );

  spi_frame_tx #(.FRAME_BYTES(1), .CLK_DIV(1), .INTER_BYTE_GAP(1)) dut_s (
    .clk(clk), .rst(rst), .begin_transmission(begin_s), .data_in(data_s),
    .sclk(sclk_s), .mosi(mosi_s), .ss(ss_s), .end_transmission(end_s),
    .busy(busy_s), .byte_count(byte_count_s)
  );

  // Slave-side sniffers: sample mosi on rising sclk while ss is low.
  logic [7:0] cap [$];
  logic [7:0] cap_s [$];
  logic [7:0] sh = 8'h00, sh_s = 8'h00;
  int nb = 0, nb_s = 0, sclk_edges = 0;

  always @(posedge sclk) sclk_edges++;

  always @(posedge sclk or posedge ss) begin
    if (ss) nb = 0;
    else begin
      sh = {sh[6:0], mosi};
      nb++;
      if (nb == 8) begin cap.push_back(sh); nb = 0; end
    end
  end

  always @(posedge sclk_s or posedge ss_s) begin
    if (ss_s) nb_s = 0;
    else begin
      sh_s = {sh_s[6:0], mosi_s};
      nb_s++;
      if (nb_s == 8) begin cap_s.push_back(sh_s); nb_s = 0; end
    end
  end

  task automatic load_frame();
    for (int k = 0; k < 19; k++) data_in[151-8*k -: 8] = frame_bytes[k];
  endtask

  // Pulses begin for one edge; returns at the negedge of cycle T+1.
  task automatic start_frame();
    @(negedge clk); begin_tx = 1'b1;
    @(negedge clk); begin_tx = 1'b0;
  endtask

  // Observes n cycles starting with the current one (cycle 1 = T+1).
  task automatic run_cycles(input int n, output int first_end, output int pulses, output logic ss_at_end);
    first_end = 0; pulses = 0; ss_at_end = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      if (end_tx) begin
        pulses++;
        if (first_end == 0) begin first_end = i; ss_at_end = ss; end
      end
    end
  endtask

  task automatic test_reset();
    int e0;
    rst = 1'b1; begin_tx = 1'b0; begin_s = 1'b0; data_in = '0; data_s = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (ss !== 1'b1)          begin errors++; $display("FAIL reset_ss got=%b exp=1", ss); end
    checks++; if (sclk !== 1'b0)        begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (end_tx !== 1'b0)      begin errors++; $display("FAIL reset_end got=%b exp=0", end_tx); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (byte_count !== 5'd0)  begin errors++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
    checks++; if (mosi !== 1'b0)        begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    rst = 1'b0;
    e0 = sclk_edges;
    repeat (100) @(negedge clk);
    checks++; if (sclk_edges - e0 !== 0) begin errors++; $display("FAIL idle_sclk_edges got=%0d exp=0", sclk_edges - e0); end
    checks++; if (ss !== 1'b1)           begin errors++; $display("FAIL idle_ss got=%b exp=1", ss); end
  endtask

  task automatic test_normal_frame();
    int base, first, pulses;
    logic ss_end;
    load_frame();
    base = cap.size();
    start_frame();
    checks++; if (ss !== 1'b0) begin errors++; $display("FAIL frame_ss_fall got=%b exp=0", ss); end
    run_cycles(EXP_END + 20, first, pulses, ss_end);
    checks++; if (first !== EXP_END) begin errors++; $display("FAIL frame_end_time got=%0d exp=%0d", first, EXP_END); end
    checks++; if (pulses !== 1)      begin errors++; $display("FAIL frame_end_pulses got=%0d exp=1", pulses); end
    checks++; if (ss_end !== 1'b1)   begin errors++; $display("FAIL frame_ss_at_end got=%b exp=1", ss_end); end
    checks++; if (cap.size() - base !== EXP_N) begin errors++; $display("FAIL frame_byte_total got=%0d exp=%0d", cap.size() - base, EXP_N); end
    for (int k = 0; k < EXP_N; k++) begin
      checks++;
      if (cap[base+k] !== frame_bytes[k]) begin errors++; $display("FAIL frame_byte[%0d] got=%h exp=%h", k, cap[base+k], frame_bytes[k]); end
    end
    checks++; if (byte_count !== 5'(EXP_N)) begin errors++; $display("FAIL frame_byte_count got=%0d exp=%0d", byte_count, EXP_N); end
    checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL frame_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int base, first, pulses;
    load_frame();
    base = cap.size();
    first = 0; pulses = 0;
    @(negedge clk); begin_tx = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (i == 10)   data_in = {19{8'hFF}};
      if (i == 500)  begin_tx = 1'b0;
      if (i == 600)  begin_tx = 1'b1;
      if (i == 601)  begin_tx = 1'b0;
      if (i == 800)  begin_tx = 1'b1;
      if (i == 1300) begin_tx = 1'b0;
      if (end_tx) begin pulses++; if (first == 0) first = i; end
    end
    checks++; if (pulses !== 1)      begin errors++; $display("FAIL held_begin_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== EXP_END) begin errors++; $display("FAIL held_begin_end_time got=%0d exp=%0d", first, EXP_END); end
    checks++; if (cap.size() - base !== EXP_N) begin errors++; $display("FAIL held_begin_byte_total got=%0d exp=%0d", cap.size() - base, EXP_N); end
    for (int k = 0; k < EXP_N; k++) begin
      checks++;
      if (cap[base+k] !== frame_bytes[k]) begin errors++; $display("FAIL held_begin_byte[%0d] got=%h exp=%h", k, cap[base+k], frame_bytes[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, first, pulses;
    logic ss_end;
    load_frame();
    start_frame();
    repeat (379) @(negedge clk);
    checks++; if (byte_count !== 5'd5) begin errors++; $display("FAIL midrst_before got=%0d exp=5", byte_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ss !== 1'b1)         begin errors++; $display("FAIL midrst_ss got=%b exp=1", ss); end
    checks++; if (sclk !== 1'b0)       begin errors++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
    checks++; if (end_tx !== 1'b0)     begin errors++; $display("FAIL midrst_end got=%b exp=0", end_tx); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (byte_count !== 5'd0) begin errors++; $display("FAIL midrst_byte_count got=%0d exp=0", byte_count); end
    rst = 1'b0;
    run_cycles(40, first, pulses, ss_end);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_end got=%0d exp=0", pulses); end
    base = cap.size();
    start_frame();
    run_cycles(EXP_END + 10, first, pulses, ss_end);
    checks++; if (first !== EXP_END) begin errors++; $display("FAIL midrst_refr_end_time got=%0d exp=%0d", first, EXP_END); end
    checks++; if (cap.size() - base !== EXP_N) begin errors++; $display("FAIL midrst_refr_total got=%0d exp=%0d", cap.size() - base, EXP_N); end
    for (int k = 0; k < EXP_N; k++) begin
      checks++;
      if (cap[base+k] !== frame_bytes[k]) begin errors++; $display("FAIL midrst_refr_byte[%0d] got=%h exp=%h", k, cap[base+k], frame_bytes[k]); end
    end
  endtask

  task automatic test_small_config();
    int base, first, pulses;
    data_s = 8'hA5;
    base = cap_s.size();
    first = 0; pulses = 0;
    @(negedge clk); begin_s = 1'b1;
    @(negedge clk); begin_s = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) @(negedge clk);
      if (end_s) begin pulses++; if (first == 0) first = i; end
    end
    checks++; if (first !== 18)  begin errors++; $display("FAIL small_end_time got=%0d exp=18", first); end
    checks++; if (pulses !== 1)  begin errors++; $display("FAIL small_end_pulses got=%0d exp=1", pulses); end
    checks++; if (cap_s.size() - base !== 1) begin errors++; $display("FAIL small_byte_total got=%0d exp=1", cap_s.size() - base); end
    checks++; if (cap_s[base] !== 8'hA5)     begin errors++; $display("FAIL small_byte got=%h exp=a5", cap_s[base]); end
    checks++; if (byte_count_s !== 5'd1)     begin errors++; $display("FAIL small_byte_count got=%0d exp=1", byte_count_s); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
